// File: rtl/riscy_pkg.sv
// Shared types and encodings for the multicycle RV32I control slice.
// State, opcode and datapath-select codes used by ctrl and its decoders.
package riscy_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] s;
    s = IMM_I;
    case (op)
      OP_STORE:  s = IMM_S;
      OP_BRANCH: s = IMM_B;
      OP_JAL:    s = IMM_J;
      default:   s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU operation decode for register and immediate arithmetic.
// Flags funct3 values outside the supported subset.
module ctrl_alu_dec
  import riscy_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [2:0] alu_ctrl,
  output logic       bad
);

  logic is_r;

  assign is_r = (op == OP_RTYPE);

  always_comb begin
    alu_ctrl = ALU_ADD;
    bad      = 1'b0;
    case (funct3)
      F3_ADD:  alu_ctrl = (is_r && funct7) ? ALU_SUB : ALU_ADD;
      F3_SLT:  alu_ctrl = ALU_SLT;
      F3_OR:   alu_ctrl = ALU_OR;
      F3_AND:  alu_ctrl = ALU_AND;
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle RV32I control FSM: sequences fetch through writeback
// over a shared memory and ALU, with memory handshake and trap.
module ctrl_multicycle
  import riscy_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit BNE_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  state_t     nxt;
  logic       rdy;
  logic [2:0] alu_dec;
  logic       alu_bad;
  logic       br_ok;
  logic       br_take;

  logic       pcw;
  logic       adr;
  logic       mw;
  logic       irw;
  logic       rw;
  logic       done;
  logic       ill;
  logic [1:0] res;
  logic [1:0] srca;
  logic [1:0] srcb;
  logic [2:0] aluc;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  ctrl_alu_dec u_alu_dec (
    .op       (op),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (alu_dec),
    .bad      (alu_bad)
  );

  assign br_ok = (funct3 == F3_BEQ)
               | (BNE_EN & (funct3 == F3_BNE));

  assign br_take = ((funct3 == F3_BEQ) & Zero)
                 | (BNE_EN & (funct3 == F3_BNE) & ~Zero);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    pcw  = 1'b0;
    adr  = 1'b0;
    mw   = 1'b0;
    irw  = 1'b0;
    rw   = 1'b0;
    done = 1'b0;
    ill  = 1'b0;
    res  = RES_ALUOUT;
    srca = SRCA_PC;
    srcb = SRCB_REGB;
    aluc = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        srcb = SRCB_FOUR;
        res  = RES_ALURES;
        irw  = rdy;
        pcw  = rdy;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        // branch/jal target lands in ALUOut here
        srca = SRCA_OLDPC;
        srcb = SRCB_IMM;
        case (op)
          OP_LOAD,
          OP_STORE:  nxt = S_MEMADR;
          OP_RTYPE:  nxt = S_EXECR;
          OP_ITYPE:  nxt = S_EXECI;
          OP_BRANCH: nxt = S_BRANCH;
          OP_JAL:    nxt = S_JAL;
          default:   nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srca = SRCA_REGA;
        srcb = SRCB_IMM;
        nxt  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        if (rdy) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        res  = RES_DATA;
        rw   = 1'b1;
        done = 1'b1;
        nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr  = 1'b1;
        mw   = 1'b1;
        done = rdy;
        if (rdy) nxt = S_FETCH;
      end
      S_EXECR,
      S_EXECI: begin
        srca = SRCA_REGA;
        srcb = (state == S_EXECR) ? SRCB_REGB : SRCB_IMM;
        aluc = alu_dec;
        nxt  = alu_bad ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
        nxt  = S_FETCH;
      end
      S_BRANCH: begin
        srca = SRCA_REGA;
        srcb = SRCB_REGB;
        aluc = ALU_SUB;
        pcw  = br_ok & br_take;
        done = br_ok;
        nxt  = br_ok ? S_FETCH : S_TRAP;
      end
      S_JAL: begin
        srca = SRCA_OLDPC;
        srcb = SRCB_FOUR;
        pcw  = 1'b1;
        nxt  = S_ALUWB;
      end
      S_TRAP: begin
        ill = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // reset forces every enable and select low, aborting any access
  assign PCWrite    = ~reset & pcw;
  assign AdrSrc     = ~reset & adr;
  assign MemWrite   = ~reset & mw;
  assign IRWrite    = ~reset & irw;
  assign RegWrite   = ~reset & rw;
  assign instr_done = ~reset & done;
  assign illegal    = ~reset & ill;
  assign ResultSrc  = reset ? 2'b00 : res;
  assign ALUSrcA    = reset ? 2'b00 : srca;
  assign ALUSrcB    = reset ? 2'b00 : srcb;
  assign ALUControl = reset ? 3'b000 : aluc;
  assign ImmSrc     = reset ? 2'b00 : imm_sel(op);

endmodule

// File: tb/tb_ctrl_multicycle.sv
// Directed bench for ctrl_multicycle: per-scenario tasks with
// hand-derived expected control values.
module tb_ctrl_multicycle;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_done;
  logic       illegal;

  wire [17:0] ctl1;

  int passed;
  int total;

  ctrl_multicycle u0 (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  ctrl_multicycle #(
    .MEM_HANDSHAKE (1'b0),
    .BNE_EN        (1'b0)
  ) u1 (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7     (funct7),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (ctl1[17]),
    .AdrSrc     (ctl1[16]),
    .MemWrite   (ctl1[15]),
    .IRWrite    (ctl1[14]),
    .RegWrite   (ctl1[13]),
    .ResultSrc  (ctl1[12:11]),
    .ALUSrcA    (ctl1[10:9]),
    .ALUSrcB    (ctl1[8:7]),
    .ImmSrc     (ctl1[6:5]),
    .ALUControl (ctl1[4:2]),
    .instr_done (ctl1[1]),
    .illegal    (ctl1[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look;
    #3;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [17:0] all0;
    op = 7'b1101111;
    funct3 = 3'b000;
    funct7 = 1'b0;
    Zero = 1'b0;
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    look();
    all0 = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            ALUControl, instr_done, illegal};
    total++;
    if (all0 !== 18'b0)
      $display("FAIL reset_outs got %b want %b", all0, 18'b0);
    else passed++;
    total++;
    if (ctl1 !== 18'b0)
      $display("FAIL reset_outs_u1 got %b want %b", ctl1, 18'b0);
    else passed++;
    tick();
    reset = 1'b0;
    look();
    total++;
    if ({IRWrite, PCWrite, ImmSrc} !== 4'b1111)
      $display("FAIL reset_fetch got %b want %b",
               {IRWrite, PCWrite, ImmSrc}, 4'b1111);
    else passed++;
  endtask

  task automatic test_rtype_sub;
    op = 7'b0110011;
    funct3 = 3'b000;
    funct7 = 1'b1;
    mem_ready = 1'b1;
    do_reset();
    look();
    total++;
    if ({IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
         ResultSrc, ALUControl} !== 12'b1_1_0_00_10_10_000)
      $display("FAIL r_fetch got %b want %b",
               {IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ALUControl}, 12'b1_1_0_00_10_10_000);
    else passed++;
    tick();
    look();
    total++;
    if ({PCWrite, IRWrite, ALUSrcA, ALUSrcB} !== 6'b0_0_01_01)
      $display("FAIL r_decode got %b want %b",
               {PCWrite, IRWrite, ALUSrcA, ALUSrcB}, 6'b000101);
    else passed++;
    tick();
    look();
    total++;
    if ({ALUSrcA, ALUSrcB, ALUControl, RegWrite} !== 8'b10_00_001_0)
      $display("FAIL r_exec_sub got %b want %b",
               {ALUSrcA, ALUSrcB, ALUControl, RegWrite}, 8'b10000010);
    else passed++;
    tick();
    look();
    total++;
    if ({RegWrite, instr_done, ResultSrc} !== 4'b1_1_00)
      $display("FAIL r_aluwb got %b want %b",
               {RegWrite, instr_done, ResultSrc}, 4'b1100);
    else passed++;
    tick();
    look();
    total++;
    if ({IRWrite, RegWrite} !== 2'b10)
      $display("FAIL r_refetch got %b want %b",
               {IRWrite, RegWrite}, 2'b10);
    else passed++;
  endtask

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       bad;
  } alu_vec_t;

  task automatic test_alu_decode;
    alu_vec_t t[7];
    t[0] = '{7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011, 1'b0};
    t[1] = '{7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010, 1'b0};
    t[2] = '{7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101, 1'b0};
    t[3] = '{7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0};
    t[4] = '{7'b0010011, 3'b010, 1'b0, 2'b01, 3'b101, 1'b0};
    t[5] = '{7'b0110011, 3'b001, 1'b0, 2'b00, 3'b000, 1'b1};
    t[6] = '{7'b0010011, 3'b100, 1'b0, 2'b01, 3'b000, 1'b1};
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = t[i].op;
      funct3 = t[i].f3;
      funct7 = t[i].f7;
      do_reset();
      tick();
      tick();
      look();
      if (!t[i].bad) begin
        total++;
        if ({ALUSrcB, ALUControl} !== {t[i].srcb, t[i].alu})
          $display("FAIL alu_dec[%0d] got %b want %b", i,
                   {ALUSrcB, ALUControl}, {t[i].srcb, t[i].alu});
        else passed++;
      end
      tick();
      look();
      total++;
      if ({RegWrite, illegal} !== {~t[i].bad, t[i].bad})
        $display("FAIL alu_wb_trap[%0d] got %b want %b", i,
                 {RegWrite, illegal}, {~t[i].bad, t[i].bad});
      else passed++;
    end
  endtask

  task automatic test_lw_wait;
    int rw_cnt;
    int done_cyc;
    rw_cnt = 0;
    done_cyc = 0;
    op = 7'b0000011;
    funct3 = 3'b010;
    funct7 = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    look();
    total++;
    if ({ALUSrcA, ALUSrcB, ImmSrc} !== 6'b10_01_00)
      $display("FAIL lw_memadr got %b want %b",
               {ALUSrcA, ALUSrcB, ImmSrc}, 6'b100100);
    else passed++;
    for (int c = 4; c <= 8; c++) begin
      tick();
      mem_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
      look();
      if (RegWrite) rw_cnt++;
      if (instr_done && done_cyc == 0) done_cyc = c;
      if (c == 4) begin
        total++;
        if ({AdrSrc, ResultSrc, RegWrite} !== 4'b1_00_0)
          $display("FAIL lw_memread got %b want %b",
                   {AdrSrc, ResultSrc, RegWrite}, 4'b1000);
        else passed++;
      end
      if (c == 7) begin
        total++;
        if ({RegWrite, ResultSrc} !== 3'b1_01)
          $display("FAIL lw_memwb got %b want %b",
                   {RegWrite, ResultSrc}, 3'b101);
        else passed++;
      end
    end
    total++;
    if (rw_cnt !== 1)
      $display("FAIL lw_regwrite_cnt got %0d want 1", rw_cnt);
    else passed++;
    total++;
    if (done_cyc !== 7)
      $display("FAIL lw_done_cycle got %0d want 7", done_cyc);
    else passed++;
  endtask

  task automatic test_sw_wait;
    int mw_cnt;
    int done_k;
    mw_cnt = 0;
    done_k = -1;
    op = 7'b0100011;
    funct3 = 3'b010;
    funct7 = 1'b0;
    mem_ready = 1'b0;
    do_reset();
    look();
    total++;
    if ({IRWrite, PCWrite} !== 2'b00)
      $display("FAIL fetch_wait got %b want %b",
               {IRWrite, PCWrite}, 2'b00);
    else passed++;
    tick();
    mem_ready = 1'b1;
    look();
    total++;
    if ({IRWrite, PCWrite} !== 2'b11)
      $display("FAIL fetch_ready got %b want %b",
               {IRWrite, PCWrite}, 2'b11);
    else passed++;
    tick();
    look();
    total++;
    if (ImmSrc !== 2'b01)
      $display("FAIL sw_immsrc got %b want %b", ImmSrc, 2'b01);
    else passed++;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ready = (k == 3) ? 1'b1 : 1'b0;
      look();
      if (MemWrite && AdrSrc) mw_cnt++;
      if (instr_done && done_k < 0) done_k = k;
    end
    total++;
    if (mw_cnt !== 4)
      $display("FAIL sw_memwrite_cnt got %0d want 4", mw_cnt);
    else passed++;
    total++;
    if (done_k !== 3)
      $display("FAIL sw_done_slot got %0d want 3", done_k);
    else passed++;
    tick();
    look();
    total++;
    if ({MemWrite, IRWrite} !== 2'b01)
      $display("FAIL sw_to_fetch got %b want %b",
               {MemWrite, IRWrite}, 2'b01);
    else passed++;
  endtask

  typedef struct packed {
    logic [2:0] f3;
    logic       z;
    logic       pcw;
    logic       ok;
  } br_vec_t;

  task automatic test_branch;
    br_vec_t t[5];
    t[0] = '{3'b001, 1'b0, 1'b1, 1'b1};
    t[1] = '{3'b001, 1'b1, 1'b0, 1'b1};
    t[2] = '{3'b000, 1'b1, 1'b1, 1'b1};
    t[3] = '{3'b000, 1'b0, 1'b0, 1'b1};
    t[4] = '{3'b100, 1'b1, 1'b0, 1'b0};
    op = 7'b1100011;
    funct7 = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      funct3 = t[i].f3;
      Zero = t[i].z;
      do_reset();
      tick();
      tick();
      look();
      total++;
      if ({PCWrite, instr_done, ALUControl, ALUSrcA, ALUSrcB}
          !== {t[i].pcw, t[i].ok, 3'b001, 2'b10, 2'b00})
        $display("FAIL branch[%0d] got %b want %b", i,
                 {PCWrite, instr_done, ALUControl, ALUSrcA, ALUSrcB},
                 {t[i].pcw, t[i].ok, 3'b001, 2'b10, 2'b00});
      else passed++;
      tick();
      look();
      total++;
      if ({IRWrite, illegal} !== {t[i].ok, ~t[i].ok})
        $display("FAIL branch_next[%0d] got %b want %b", i,
                 {IRWrite, illegal}, {t[i].ok, ~t[i].ok});
      else passed++;
    end
    Zero = 1'b0;
  endtask

  task automatic test_bne_disabled;
    op = 7'b1100011;
    funct3 = 3'b001;
    funct7 = 1'b0;
    Zero = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    look();
    total++;
    if (ctl1 !== {5'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 2'b00})
      $display("FAIL bne_off_branch got %b want %b", ctl1,
               {5'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 2'b00});
    else passed++;
    tick();
    look();
    total++;
    if (ctl1 !== {5'b0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 2'b01})
      $display("FAIL bne_off_trap got %b want %b", ctl1,
               {5'b0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 2'b01});
    else passed++;
  endtask

  task automatic test_jal;
    op = 7'b1101111;
    funct3 = 3'b000;
    funct7 = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    tick();
    look();
    total++;
    if (ImmSrc !== 2'b11)
      $display("FAIL jal_immsrc got %b want %b", ImmSrc, 2'b11);
    else passed++;
    tick();
    look();
    total++;
    if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegWrite}
        !== 11'b1_01_10_00_000_0)
      $display("FAIL jal_state got %b want %b",
               {PCWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
                RegWrite}, 11'b10110000000);
    else passed++;
    tick();
    look();
    total++;
    if ({RegWrite, ResultSrc, instr_done, PCWrite} !== 5'b1_00_1_0)
      $display("FAIL jal_aluwb got %b want %b",
               {RegWrite, ResultSrc, instr_done, PCWrite}, 5'b10010);
    else passed++;
    tick();
    look();
    total++;
    if (IRWrite !== 1'b1)
      $display("FAIL jal_refetch got %b want %b", IRWrite, 1'b1);
    else passed++;
  endtask

  task automatic test_trap_sticky;
    int ill_cnt;
    int en_cnt;
    ill_cnt = 0;
    en_cnt = 0;
    op = 7'b1111111;
    funct3 = 3'b000;
    funct7 = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    look();
    total++;
    if ({illegal, PCWrite, IRWrite, MemWrite, RegWrite, instr_done}
        !== 6'b1_00000)
      $display("FAIL trap_enter got %b want %b",
               {illegal, PCWrite, IRWrite, MemWrite, RegWrite,
                instr_done}, 6'b100000);
    else passed++;
    op = 7'b0110011;
    for (int k = 0; k < 4; k++) begin
      tick();
      look();
      if (illegal) ill_cnt++;
      if (PCWrite | IRWrite | MemWrite | RegWrite | instr_done)
        en_cnt++;
    end
    total++;
    if ({ill_cnt, en_cnt} !== {32'd4, 32'd0})
      $display("FAIL trap_sticky got ill=%0d en=%0d want ill=4 en=0",
               ill_cnt, en_cnt);
    else passed++;
    reset = 1'b1;
    tick();
    look();
    total++;
    if (illegal !== 1'b0)
      $display("FAIL trap_reset got %b want %b", illegal, 1'b0);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_reset_memwrite;
    op = 7'b0100011;
    funct3 = 3'b010;
    funct7 = 1'b0;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    look();
    total++;
    if (MemWrite !== 1'b1)
      $display("FAIL rst_mw_pre got %b want %b", MemWrite, 1'b1);
    else passed++;
    tick();
    reset = 1'b1;
    look();
    total++;
    if (MemWrite !== 1'b0)
      $display("FAIL rst_mw_during got %b want %b", MemWrite, 1'b0);
    else passed++;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    look();
    total++;
    if ({MemWrite, IRWrite, AdrSrc} !== 3'b010)
      $display("FAIL rst_mw_fetch got %b want %b",
               {MemWrite, IRWrite, AdrSrc}, 3'b010);
    else passed++;
  endtask

  task automatic test_no_handshake;
    op = 7'b0110011;
    funct3 = 3'b000;
    funct7 = 1'b0;
    mem_ready = 1'b0;
    do_reset();
    look();
    total++;
    if (ctl1 !== {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00})
      $display("FAIL nohs_fetch got %b want %b", ctl1,
               {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00});
    else passed++;
    tick();
    look();
    total++;
    if (ctl1 !== {5'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00})
      $display("FAIL nohs_decode got %b want %b", ctl1,
               {5'b0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00});
    else passed++;
    total++;
    if ({IRWrite, PCWrite} !== 2'b00)
      $display("FAIL hs_still_wait got %b want %b",
               {IRWrite, PCWrite}, 2'b00);
    else passed++;
    mem_ready = 1'b1;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    op = 7'b0;
    funct3 = 3'b0;
    funct7 = 1'b0;
    Zero = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_rtype_sub();
    test_alu_decode();
    test_lw_wait();
    test_sw_wait();
    test_branch();
    test_bne_disabled();
    test_jal();
    test_trap_sticky();
    test_reset_memwrite();
    test_no_handshake();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
